// File: rtl/mult_share_arbiter.sv
// Round-robin share of one approx_multiplier among NUM_REQ requesters.
// Two registered stages: operand capture, then the tagged product.

module approx_multiplier (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        mode_i,
  output logic [31:0] product_o
);
  logic [15:0] a_m, b_m;

  // Approximate mode drops the low nibble of each operand before multiplying.
  assign a_m = mode_i ? a_i : {a_i[15:4], 4'h0};
  assign b_m = mode_i ? b_i : {b_i[15:4], 4'h0};
  assign product_o = 32'(a_m) * 32'(b_m);
endmodule

module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [16*NUM_REQ-1:0] a_flat,
  input  logic [16*NUM_REQ-1:0] b_flat,
  input  logic [NUM_REQ-1:0]    mode_vec,
  input  logic [1:0]            mode_force,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_result,
  output logic [ID_W-1:0]       out_id,
  output logic                  out_mode
);
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] hi_idx, lo_idx, gnt_idx;
  logic            hi_hit, lo_hit, gnt_any, grant, stall, eff_mode;

  logic            s1_valid_q;
  logic [15:0]     s1_a_q, s1_b_q;
  logic [ID_W-1:0] s1_id_q;
  logic            s1_mode_q;
  logic [31:0]     mult_p;

  logic            out_valid_q;
  logic [31:0]     out_result_q;
  logic [ID_W-1:0] out_id_q;
  logic            out_mode_q;

  assign stall = out_valid_q && !out_ready;

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr_q))) begin
        hi_hit = 1'b1;
        hi_idx = ID_W'(i);
      end
      if (req[i]) begin
        lo_hit = 1'b1;
        lo_idx = ID_W'(i);
      end
    end
    gnt_any = hi_hit || lo_hit;
    gnt_idx = hi_hit ? hi_idx : lo_idx;
  end

  assign grant = rst_n && !stall && gnt_any;

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_REQ; i++)
      gnt[i] = grant && (gnt_idx == ID_W'(i));
  end

  always_comb begin
    case (mode_force)
      2'b01:   eff_mode = 1'b0;
      2'b10:   eff_mode = 1'b1;
      default: eff_mode = mode_vec[gnt_idx];
    endcase
  end

  assign ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

  approx_multiplier u_mult (
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .mode_i   (s1_mode_q),
    .product_o(mult_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_id_q      <= '0;
      s1_mode_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_id_q     <= '0;
      out_mode_q   <= 1'b0;
    end else if (!stall) begin
      s1_valid_q  <= grant;
      out_valid_q <= s1_valid_q;
      if (grant) begin
        ptr_q     <= ptr_d;
        s1_a_q    <= a_flat[16*gnt_idx +: 16];
        s1_b_q    <= b_flat[16*gnt_idx +: 16];
        s1_id_q   <= gnt_idx;
        s1_mode_q <= eff_mode;
      end
      if (s1_valid_q) begin
        out_result_q <= mult_p;
        out_id_q     <= s1_id_q;
        out_mode_q   <= s1_mode_q;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_id     = out_id_q;
  assign out_mode   = out_mode_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized + directed bench for mult_share_arbiter against a queue-based reference.

module tb_mult_share_arbiter;
  localparam int N    = 4;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [16*N-1:0] a_flat = '0, b_flat = '0;
  logic [N-1:0]    mode_vec = '0;
  logic [1:0]      mode_force = 2'b00;
  logic [N-1:0]    gnt;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [31:0]     out_result;
  logic [ID_W-1:0] out_id;
  logic            out_mode;

  mult_share_arbiter #(.NUM_REQ(N), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .mode_vec(mode_vec), .mode_force(mode_force), .gnt(gnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_id(out_id), .out_mode(out_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    bit          mode;
    logic [31:0] res;
    int          age;
  } txn_t;

  txn_t q[$];
  int   ptr = 0;
  int   last_g = -1;
  int   n_err = 0, n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input bit m);
    logic [31:0] x, y;
    x = 32'(a);
    y = 32'(b);
    if (m) return x * y;
    return ((x >> 4) * (y >> 4)) << 8;
  endfunction

  function automatic bit model_valid();
    return (q.size() > 0) && (q[0].age >= 2);
  endfunction

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic bit eff_mode(input int i);
    if (mode_force == 2'b01) return 1'b0;
    if (mode_force == 2'b10) return 1'b1;
    return mode_vec[i];
  endfunction

  // One clock: inputs were set after the previous falling edge.
  task automatic cycle();
    bit   stall;
    int   g;
    logic [N-1:0] eg;
    txn_t t;
    #1;
    stall = model_valid() && !out_ready;
    g = stall ? -1 : pick();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("out_valid", 32'(out_valid), 32'(model_valid()));
    if (model_valid()) begin
      chk("out_id", 32'(out_id), 32'(q[0].id));
      chk("out_mode", 32'(out_mode), 32'(q[0].mode));
      chk("out_result", out_result, q[0].res);
    end
    if (g >= 0) begin
      t.id   = g;
      t.mode = eff_mode(g);
      t.res  = ref_mul(a_flat[16*g +: 16], b_flat[16*g +: 16], t.mode);
      t.age  = 0;
    end
    @(posedge clk);
    if (!stall) begin
      if (model_valid()) void'(q.pop_front());
      foreach (q[k]) q[k].age++;
      if (g >= 0) begin
        t.age = 1;
        q.push_back(t);
        ptr = (g + 1) % N;
      end
    end
    last_g = g;
    @(negedge clk);
  endtask

  task automatic model_clear();
    q.delete();
    ptr = 0;
    last_g = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b, input bit m);
    a_flat[16*i +: 16] = a;
    b_flat[16*i +: 16] = b;
    mode_vec[i] = m;
  endtask

  task automatic new_ops(input int i);
    logic [15:0] a, b;
    a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
    b = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
    set_ops(i, a, b, 1'($urandom_range(0, 1)));
  endtask

  task automatic rand_drive();
    for (int i = 0; i < N; i++) begin
      if (req[i] && last_g == i) begin
        if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
        else new_ops(i);
      end else if (!req[i] && $urandom_range(0, 2) == 0) begin
        req[i] = 1'b1;
        new_ops(i);
      end
    end
    out_ready = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 15) == 0) mode_force = 2'($urandom_range(0, 3));
  endtask

  initial begin
    logic [31:0] held_res;
    logic [ID_W-1:0] held_id;

    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single exact request: result two cycles after the grant.
    set_ops(2, 16'h0300, 16'h0200, 1'b1);
    req = 4'b0100;
    #1 chk("single_gnt", 32'(gnt), 32'h4);
    cycle();
    req = '0;
    cycle();
    chk("single_valid_t2", 32'(out_valid), 32'd1);
    chk("single_id", 32'(out_id), 32'd2);
    chk("single_mode", 32'(out_mode), 32'd1);
    chk("single_hi", 32'(out_result[31:16]), 32'h6);
    cycle();

    // Round robin with all four requesting from pointer 0.
    do_reset();
    for (int i = 0; i < N; i++) new_ops(i);
    req = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1 chk("rr_order", 32'(gnt), 32'(1 << (k % N)));
      if (k >= 2) chk("rr_out_id", 32'(out_id), 32'((k - 2) % N));
      cycle();
    end

    // Backpressure: stall 3 cycles, pipeline holds, then drains in order.
    held_res = out_result;
    held_id  = out_id;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_gnt", 32'(gnt), 32'd0);
      chk("stall_res", out_result, held_res);
      chk("stall_id", 32'(out_id), 32'(held_id));
      cycle();
    end
    req = '0;
    out_ready = 1'b1;
    repeat (4) cycle();
    chk("drain_empty", 32'(out_valid), 32'd0);

    // mode_force: force approximate over exact mode_vec, then force exact.
    for (int i = 0; i < N; i++) set_ops(i, 16'hABCD, 16'h1237, 1'b1);
    mode_force = 2'b01;
    req = 4'b0010;
    cycle();
    req = '0;
    cycle();
    chk("force_approx_mode", 32'(out_mode), 32'd0);
    chk("force_approx_res", out_result, ref_mul(16'hABCD, 16'h1237, 1'b0));
    mode_vec = '0;
    mode_force = 2'b10;
    req = 4'b0001;
    cycle();
    req = '0;
    cycle();
    chk("force_exact_mode", 32'(out_mode), 32'd1);
    chk("force_exact_res", out_result, 32'hABCD * 32'h1237);
    cycle();
    mode_force = 2'b00;

    // Pointer wrap with sparse requests.
    do_reset();
    req = 4'b1000;
    #1 chk("wrap_g3", 32'(gnt), 32'h8);
    cycle();
    req = 4'b1001;
    #1 chk("wrap_g0", 32'(gnt), 32'h1);
    cycle();
    #1 chk("wrap_g3b", 32'(gnt), 32'h8);
    cycle();
    req = '0;

    // Randomized traffic against the reference queue.
    for (int c = 0; c < 400; c++) begin
      rand_drive();
      cycle();
    end

    // Asynchronous reset mid-stream with a valid result pending.
    req = 4'b1111;
    out_ready = 1'b1;
    mode_force = 2'b00;
    repeat (3) cycle();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_gnt", 32'(gnt), 32'd0);
    chk("async_rst_id", 32'(out_id), 32'd0);
    model_clear();
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0001;
    #1 chk("post_rst_g0", 32'(gnt), 32'h1);
    cycle();
    req = '0;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one approx_multiplier instance between NUM_REQ requesters, such as DCT row/column MAC lanes.
- Arbitration is round-robin.
- Operands are registered before the multiplier and the product is registered after it.
- Each result is returned tagged with the requester ID and the mode used; backpressure comes from the consumer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester request; held high with operands stable until the matching gnt bit is seen.
- a_flat  input  16*NUM_REQ  operand A; requester i uses bits [16i+15:16i].
- b_flat  input  16*NUM_REQ  operand B; same packing as a_flat.
- mode_vec  input  NUM_REQ  per-requester mode: 0 = approximate, 1 = exact.
- mode_force  input  2  00 = use mode_vec; 01 = force approximate; 10 = force exact; 11 = same as 00.
- gnt  output  NUM_REQ  combinational one-hot grant, at most one bit set; high for exactly the cycle its operands are captured.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result when out_valid && out_ready.
- out_result  output  32  product from approx_multiplier for the captured A, B and effective mode.
- out_id  output  ID_W  index of the requester that owns out_result.
- out_mode  output  1  effective mode applied to this result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_result=0, out_id=0, out_mode=0.
  - Stage-1 valid=0 and stage-1 registers=0.
  - Round-robin pointer=0.
  - gnt=0 while rst_n is low.
- Reset mid-operation: in-flight transactions are discarded, no result is produced for them, and requesters must re-request.
- stall = out_valid && !out_ready.
- Arbitration, when not stalled:
  - Search req starting at pointer index p, wrapping upward: p, p+1, …, NUM_REQ-1, 0, …, p-1.
  - The first set bit i gets gnt[i]=1 combinationally in the same cycle.
  - While stalled: gnt=0 and no capture occurs.
- Pointer update: after a grant to i, the pointer becomes (i+1) mod NUM_REQ at the clock edge. With no grant, the pointer holds.
- Stage 1 (capture edge of a grant cycle):
  - s1_valid=1.
  - s1_a, s1_b = operands of requester i.
  - s1_id = i.
  - s1_mode = effective mode (mode_force overrides mode_vec as listed).
  - With no grant and no stall: s1_valid=0.
- Multiplier: combinational approx_multiplier(s1_a, s1_b, s1_mode).
- Stage 2, when not stalled: out_valid<=s1_valid and out_result/out_id/out_mode<=multiplier output/s1_id/s1_mode. The data registers load only when s1_valid=1; otherwise they hold their old values.
- Stall: stage 1 and stage 2 both hold all contents.
- Latency: grant in cycle t → out_valid in cycle t+2 (no stall).
- Throughput: one result per cycle. Results return in grant order; there is no reordering.
- A requester that keeps req high after its gnt is treated as a new request and re-enters arbitration from the updated pointer.
- Fairness: each continuously requesting requester is granted at least once every NUM_REQ grants.
- Simultaneous events: a grant cycle coinciding with the consumer accepting the previous result advances both stages in the same edge; no bubble is inserted.
- Changing mode_force takes effect on the next capture; in-flight results keep the mode they were captured with.
- The block has no error signalling. Operand values are unconstrained; the full 16×16 input range passes through.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 → out_valid, gnt and pointer go to 0 immediately. After release, req=0001 grants requester 0 first.
- Single exact request:
  - Stimulus: req=0100, A2=0x0300, B2=0x0200, mode_vec[2]=1.
  - gnt=0100 in cycle t.
  - Cycle t+2: out_valid=1, out_id=2, out_mode=1, out_result[31:16]=0x0006, matching the approx_multiplier model.
- Round-robin: all four req held high for 8 cycles, out_ready=1 → grant order 0,1,2,3,0,1,2,3; out_id follows the same order two cycles later; one result per cycle.
- Backpressure:
  - out_ready=0 for 3 cycles while out_valid=1 → gnt=0 during the stall; out_result/out_id stable; the stage-1 transaction is retained.
  - After out_ready=1: the two held results are delivered in order and none are lost or duplicated.
- mode_force:
  - Stimulus: mode_vec=1111 with mode_force=01 → out_mode=0 and out_result equals the model in approximate mode.
  - Switch to 10 with mode_vec=0000 → out_mode=1 for grants from the next cycle on.
- Pointer wrap with sparse requests:
  - Stimulus: grant to 3, then req=1001 → requester 0 is granted (pointer wrapped to 0).
  - Next: req=1001 → requester 3 is granted.
